// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, then
// shifts a byte, odd parity and stop bit out on device-generated clock edges.
module ps2_host_tx #(
  parameter int c_clk_mhz    = 25,
  parameter int c_inhibit_us = 120,
  parameter int c_timeout_us = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       error,
  output logic       busy
);

  localparam int c_inh_cycles = c_clk_mhz * c_inhibit_us;
  localparam int c_tmo_cycles = c_clk_mhz * c_timeout_us;
  localparam int c_inh_w      = $clog2(c_inh_cycles) + 1;
  localparam int c_tmo_w      = $clog2(c_tmo_cycles) + 1;
  localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(c_inh_cycles - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(c_tmo_cycles - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQUEST = 3'd2,
    SHIFT   = 3'd3,
    ACK     = 3'd4,
    WAITREL = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t               state_r, state_next_s;
  logic [c_inh_w-1:0]   inh_cnt_r, inh_cnt_s;
  logic [c_tmo_w-1:0]   tmo_cnt_r, tmo_cnt_s;
  logic [3:0]           bit_idx_r, bit_idx_s;
  logic [9:0]           frame_r, frame_s;
  logic                 ack_ok_r, ack_ok_s;
  logic                 clk_meta_r, clk_sync_r, clk_prev_r;
  logic                 data_meta_r, data_sync_r;
  logic                 clk_fall_s, tmo_active_s, tmo_hit_s;
  logic                 data_oe_s, done_s, error_s;
  logic                 clk_oe_r, data_oe_r, done_r, error_r, busy_r, tx_ready_r;

  // Two-flop synchronizers plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_i;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_i;
      data_sync_r <= data_meta_r;
    end
  end

  assign clk_fall_s   = clk_prev_r & ~clk_sync_r;
  assign tmo_active_s = (state_r == REQUEST) || (state_r == SHIFT) ||
                        (state_r == ACK) || (state_r == WAITREL);
  assign tmo_hit_s    = tmo_active_s && (tmo_cnt_r == c_tmo_last);

  // Next-state, datapath and pre-register output decode
  always_comb begin
    state_next_s = state_r;
    inh_cnt_s    = {c_inh_w{1'b0}};
    tmo_cnt_s    = {c_tmo_w{1'b0}};
    bit_idx_s    = bit_idx_r;
    frame_s      = frame_r;
    ack_ok_s     = ack_ok_r;
    data_oe_s    = 1'b0;
    done_s       = 1'b0;
    error_s      = 1'b0;
    case (state_r)
      IDLE: begin
        bit_idx_s = 4'd0;
        if (tx_valid && tx_ready_r) begin
          state_next_s = INHIBIT;
          frame_s      = {1'b1, odd_parity(tx_data), tx_data};
          ack_ok_s     = 1'b0;
        end else begin
          state_next_s = IDLE;
        end
      end
      INHIBIT: begin
        if (inh_cnt_r == c_inh_last) begin
          state_next_s = REQUEST;
          data_oe_s    = 1'b1;
        end else begin
          inh_cnt_s = inh_cnt_r + c_inh_w'(1);
        end
      end
      REQUEST: begin
        state_next_s = SHIFT;
        bit_idx_s    = 4'd0;
        data_oe_s    = 1'b1;
      end
      SHIFT: begin
        data_oe_s = data_oe_r;
        if (clk_fall_s) begin
          if (bit_idx_r == 4'd10) begin
            state_next_s = ACK;
            data_oe_s    = 1'b0;
          end else begin
            // Frame LSB goes out; vacated bits fill with 1 so the stop bit releases.
            data_oe_s = ~frame_r[0];
            frame_s   = {1'b1, frame_r[9:1]};
            bit_idx_s = bit_idx_r + 4'd1;
          end
        end else begin
          state_next_s = SHIFT;
        end
      end
      ACK: begin
        state_next_s = WAITREL;
        if (data_sync_r == 1'b0) begin
          ack_ok_s = 1'b1;
        end else begin
          ack_ok_s = 1'b0;
          error_s  = 1'b1;
        end
      end
      WAITREL: begin
        if (clk_sync_r && data_sync_r) begin
          state_next_s = IDLE;
          done_s       = ack_ok_r;
        end else begin
          state_next_s = WAITREL;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    // A timeout aborts anything not already finishing this cycle.
    if (tmo_hit_s && (state_next_s != IDLE)) begin
      state_next_s = IDLE;
      data_oe_s    = 1'b0;
      error_s      = 1'b1;
      done_s       = 1'b0;
    end else if (tmo_active_s) begin
      tmo_cnt_s = tmo_cnt_r + c_tmo_w'(1);
    end else begin
      tmo_cnt_s = {c_tmo_w{1'b0}};
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      inh_cnt_r  <= {c_inh_w{1'b0}};
      tmo_cnt_r  <= {c_tmo_w{1'b0}};
      bit_idx_r  <= 4'd0;
      frame_r    <= 10'h3FF;
      ack_ok_r   <= 1'b0;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      busy_r     <= 1'b0;
      tx_ready_r <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      inh_cnt_r  <= inh_cnt_s;
      tmo_cnt_r  <= tmo_cnt_s;
      bit_idx_r  <= bit_idx_s;
      frame_r    <= frame_s;
      ack_ok_r   <= ack_ok_s;
      clk_oe_r   <= (state_next_s == INHIBIT) || (state_next_s == REQUEST);
      data_oe_r  <= data_oe_s;
      done_r     <= done_s;
      error_r    <= error_s;
      busy_r     <= (state_next_s != IDLE);
      tx_ready_r <= (state_next_s == IDLE);
    end
  end

  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign done        = done_r;
  assign error       = error_r;
  assign busy        = busy_r;
  assign tx_ready    = tx_ready_r;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
- REQ-001 SHALL provide parameter c_clk_mhz, default 25, clk frequency in MHz.
- REQ-002 SHALL provide parameter c_inhibit_us, default 120, host clock-inhibit time in µs.
- REQ-003 SHALL provide parameter c_timeout_us, default 15000, per-transfer timeout in µs.
- REQ-004 SHALL provide port clk, input, 1 bit: single system clock; all logic on its rising edge.
- REQ-005 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
- REQ-006 SHALL provide port tx_data, input, 8 bits: command byte to the keyboard.
- REQ-007 SHALL provide port tx_valid, input, 1 bit: a request is present.
- REQ-008 SHALL provide port tx_ready, output, 1 bit: block is idle and can accept a byte.
- REQ-009 SHALL provide port ps2_clk_i, input, 1 bit: raw PS/2 clock pin level (asynchronous).
- REQ-010 SHALL provide port ps2_data_i, input, 1 bit: raw PS/2 data pin level (asynchronous).
- REQ-011 SHALL provide port ps2_clk_oe, output, 1 bit: 1 drives the clock pin low; 0 releases it (high-Z).
- REQ-012 SHALL provide port ps2_data_oe, output, 1 bit: 1 drives the data pin low; 0 releases it (high-Z).
- REQ-013 SHALL provide port done, output, 1 bit: one-cycle pulse when the device acknowledges the transfer.
- REQ-014 SHALL provide port error, output, 1 bit: one-cycle pulse on timeout or missing acknowledge.
- REQ-015 SHALL provide port busy, output, 1 bit: high whenever the state is not IDLE.

Function
- REQ-016 SHALL synchronize ps2_clk_i and ps2_data_i through 2 flip-flops each; a clock falling edge is detected when the previous synchronized value is 1 and the current one is 0.
- REQ-017 SHALL accept a byte when tx_valid & tx_ready are both high, latching tx_data and computing odd parity, parity = ~^tx_data.
- REQ-018 SHALL have states IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAITREL.
- REQ-019 SHALL drive tx_ready=1 only in IDLE; on accept, move to INHIBIT on the next cycle.
- REQ-020 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0, for exactly c_clk_mhz*c_inhibit_us cycles; then go to REQUEST.
- REQ-021 REQUEST: ps2_data_oe=1 (start bit 0) for one cycle with ps2_clk_oe still 1; then release ps2_clk_oe and go to SHIFT with bit index 0.
- REQ-022 SHIFT: on each detected falling edge, present the next bit in the order D0..D7 (LSB first), then parity, then stop; a bit value of 0 sets ps2_data_oe=1, a bit value of 1 sets ps2_data_oe=0; the stop bit is always released.
- REQ-023 The falling edge that presents the stop bit SHALL be the 10th edge after REQUEST; the next falling edge moves the state to ACK.
- REQ-024 ACK: sample synchronized data at that edge; 0 -> go to WAITREL with ack_ok=1; 1 -> pulse error and go to WAITREL with ack_ok=0.
- REQ-025 WAITREL: wait for both synchronized lines high, then pulse done if ack_ok and return to IDLE.
- REQ-026 SHALL run a timeout counter from leaving INHIBIT; when it reaches c_clk_mhz*c_timeout_us cycles before IDLE, it SHALL release both lines, pulse error and return to IDLE.
- REQ-027 done and error SHALL never be high in the same cycle; each transfer produces exactly one of them, except that a missing ACK produces only error.
- REQ-028 tx_valid while busy SHALL be ignored and never corrupt the latched byte.
- REQ-029 Counters SHALL be sized as $clog2 of the largest count +1 and SHALL not wrap during valid operation.

Reset
- REQ-030 On reset=1 at any clk edge (including mid-transfer), the block SHALL go to IDLE and set ps2_clk_oe=0, ps2_data_oe=0, done=0, error=0, busy=0, counters=0; tx_ready SHALL be 1 from the first cycle after reset deasserts.

Verification
- REQ-031 Send 0xED with a device model clocking at 12.5 kHz and ACKing -> clk held low 3000 cycles; bits on data 1,0,1,1,0,1,1,1, parity 1, stop 1; one done pulse; no error.
- REQ-032 Send 0x01 -> parity bit 0; send 0xFF -> parity 1; send 0x00 -> parity 1; each ends with done.
- REQ-033 Device model clocks but never pulls data low at ACK -> one error pulse, no done, lines released, return to IDLE.
- REQ-034 Device model never clocks -> error pulse exactly 375000 cycles after INHIBIT ends; both oe=0.
- REQ-035 Assert reset during SHIFT after 4 bits -> next cycle both oe=0, busy=0; a following 0xF4 transfer completes with done.
- REQ-036 Toggle tx_valid with varying tx_data while busy -> transmitted byte equals the originally accepted value, and tx_ready stays 0 until IDLE.
